// File: rtl/azimuth_frame_loader.sv
// -----------------------------------------------------------------------------
// azimuth_frame_loader
//
// Purpose:
//   Sequencer for the azimuth signal generator. It collects one SIZE-bit target
//   frame from an AXI4-Stream of WORD-bit words into a back buffer. On each
//   radar trigger it copies the back buffer into the front buffer that drives
//   the generator DATA bus, and it pulses the generator TRIG.
//   A trigger that arrives before a complete frame is waiting does not swap.
//   The previous frame repeats and the sticky UNDERRUN flag is set.
//   Malformed frames (TLAST too early or missing) set the sticky LOAD_ERR flag.
//
// Ports:
//   SYS_CLK        in   system clock
//   RST            in   asynchronous active-high reset
//   EN             in   block enable; low forces IDLE and clears DATA_OUT
//   TRIG_IN        in   single-cycle radar trigger
//   S_AXIS_TDATA   in   frame word k carries frame bits [k*WORD +: WORD]
//   S_AXIS_TVALID  in   stream valid
//   S_AXIS_TLAST   in   marks the last word (NW-1) of a frame
//   S_AXIS_TREADY  out  stream ready (registered)
//   DATA_OUT       out  front buffer to the generator DATA
//   TRIG_OUT       out  one-cycle trigger to the generator, 1 cycle after TRIG_IN
//   FRAME_CNT      out  number of successful swaps (wraps)
//   UNDERRUN       out  sticky: trigger arrived with no complete frame waiting
//   LOAD_ERR       out  sticky: framing error seen on the stream
// -----------------------------------------------------------------------------
module azimuth_frame_loader #(
    parameter int SIZE = 3200,
    parameter int WORD = 32
) (
    input  logic             SYS_CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             TRIG_IN,
    input  logic [WORD-1:0]  S_AXIS_TDATA,
    input  logic             S_AXIS_TVALID,
    input  logic             S_AXIS_TLAST,
    output logic             S_AXIS_TREADY,
    output logic [SIZE-1:0]  DATA_OUT,
    output logic             TRIG_OUT,
    output logic [31:0]      FRAME_CNT,
    output logic             UNDERRUN,
    output logic             LOAD_ERR
);

    localparam int NW   = (SIZE + WORD - 1) / WORD;
    localparam int BW   = NW * WORD;
    localparam int IDXW = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NW - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2,
        READY = 2'd3
    } state_t;

    state_t            state_reg, state_next;
    logic [IDXW-1:0]   idx_reg, idx_next;
    logic              tready_reg, tready_next;
    logic [SIZE-1:0]   data_reg, data_next;
    logic              trig_reg, trig_next;
    logic [31:0]       cnt_reg, cnt_next;
    logic              under_reg, under_next;
    logic              err_reg, err_next;
    logic              wr_en;

    // Back buffer kept as one word per entry so that each accepted word is a
    // single indexed write.
    logic [WORD-1:0]   back_reg [NW];
    logic [BW-1:0]     back_flat;

    logic accept;
    logic at_last_idx;

    assign accept      = S_AXIS_TVALID & tready_reg;
    assign at_last_idx = (idx_reg == LAST_IDX);

    generate
        for (genvar gi = 0; gi < NW; gi++) begin : g_flat
            assign back_flat[gi*WORD +: WORD] = back_reg[gi];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Next-state and registered-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        data_next  = data_reg;
        trig_next  = 1'b0;
        cnt_next   = cnt_reg;
        under_next = under_reg;
        err_next   = err_reg;
        wr_en      = 1'b0;

        if (!EN) begin
            // Disabling abandons any partial or waiting frame. The flags
            // stay sticky until the block is re-enabled.
            state_next = IDLE;
            idx_next   = '0;
            data_next  = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_next = FILL;
                    under_next = 1'b0;
                    err_next   = 1'b0;
                end

                FILL: begin
                    if (TRIG_IN) begin
                        trig_next  = 1'b1;
                        under_next = 1'b1;
                    end
                    if (accept) begin
                        wr_en = 1'b1;
                        if (S_AXIS_TLAST) begin
                            idx_next = '0;
                            if (at_last_idx) begin
                                state_next = READY;
                            end else begin
                                err_next = 1'b1;  // short frame dropped
                            end
                        end else if (at_last_idx) begin
                            // Frame too long: discard words up to the next TLAST.
                            err_next   = 1'b1;
                            idx_next   = '0;
                            state_next = DRAIN;
                        end else begin
                            idx_next = idx_reg + 1'b1;
                        end
                    end
                end

                DRAIN: begin
                    if (TRIG_IN) begin
                        trig_next  = 1'b1;
                        under_next = 1'b1;
                    end
                    if (accept && S_AXIS_TLAST) begin
                        state_next = FILL;
                        idx_next   = '0;
                    end
                end

                READY: begin
                    if (TRIG_IN) begin
                        data_next  = back_flat[SIZE-1:0];
                        trig_next  = 1'b1;
                        cnt_next   = cnt_reg + 32'd1;
                        state_next = FILL;
                    end
                end

                default: begin
                    state_next = IDLE;
                    idx_next   = '0;
                end
            endcase
        end

        // Ready is registered, so it is derived from the state being entered.
        tready_next = (state_next == FILL) || (state_next == DRAIN);
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge SYS_CLK or posedge RST) begin
        if (RST) begin
            state_reg  <= IDLE;
            idx_reg    <= '0;
            tready_reg <= 1'b0;
            data_reg   <= '0;
            trig_reg   <= 1'b0;
            cnt_reg    <= '0;
            under_reg  <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            tready_reg <= tready_next;
            data_reg   <= data_next;
            trig_reg   <= trig_next;
            cnt_reg    <= cnt_next;
            under_reg  <= under_next;
            err_reg    <= err_next;
        end
    end

    always_ff @(posedge SYS_CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NW; i++) begin
                back_reg[i] <= '0;
            end
        end else if (wr_en) begin
            back_reg[idx_reg] <= S_AXIS_TDATA;
        end
    end

    assign S_AXIS_TREADY = tready_reg;
    assign DATA_OUT      = data_reg;
    assign TRIG_OUT      = trig_reg;
    assign FRAME_CNT     = cnt_reg;
    assign UNDERRUN      = under_reg;
    assign LOAD_ERR      = err_reg;

endmodule

// File: tb/tb_azimuth_frame_loader.sv
// -----------------------------------------------------------------------------
// tb_azimuth_frame_loader
//
// Directed sequence with random frame contents for azimuth_frame_loader
// (SIZE=96, WORD=32, NW=3). Expected values come from a transaction-level
// model. The model collects words into a queue, records a complete frame as
// pending, and swaps it into the front buffer when a trigger arrives.
// -----------------------------------------------------------------------------
module tb_azimuth_frame_loader;

    localparam int SIZE = 96;
    localparam int WORD = 32;
    localparam int NW   = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             trig_in;
    logic [WORD-1:0]  tdata;
    logic             tvalid;
    logic             tlast;
    logic             tready;
    logic [SIZE-1:0]  data_out;
    logic             trig_out;
    logic [31:0]      frame_cnt;
    logic             underrun;
    logic             load_err;

    azimuth_frame_loader #(.SIZE(SIZE), .WORD(WORD)) dut (
        .SYS_CLK       (clk),
        .RST           (rst),
        .EN            (en),
        .TRIG_IN       (trig_in),
        .S_AXIS_TDATA  (tdata),
        .S_AXIS_TVALID (tvalid),
        .S_AXIS_TLAST  (tlast),
        .S_AXIS_TREADY (tready),
        .DATA_OUT      (data_out),
        .TRIG_OUT      (trig_out),
        .FRAME_CNT     (frame_cnt),
        .UNDERRUN      (underrun),
        .LOAD_ERR      (load_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // ---------------- reference model ----------------
    logic [SIZE-1:0] m_front;
    logic [SIZE-1:0] m_back;
    logic            m_ready;
    logic            m_drain;
    logic            m_under;
    logic            m_err;
    logic [31:0]     m_cnt;
    logic [31:0]     m_q[$];

    function automatic void m_reset();
        m_front = '0;
        m_back  = '0;
        m_ready = 1'b0;
        m_drain = 1'b0;
        m_under = 1'b0;
        m_err   = 1'b0;
        m_cnt   = '0;
        m_q.delete();
    endfunction

    function automatic void m_accept(input logic [31:0] d, input logic last);
        if (m_drain) begin
            if (last) m_drain = 1'b0;
            return;
        end
        m_q.push_back(d);
        if (last) begin
            if (m_q.size() == NW) begin
                for (int i = 0; i < NW; i++) m_back[i*WORD +: WORD] = m_q[i];
                m_ready = 1'b1;
            end else begin
                m_err = 1'b1;
            end
            m_q.delete();
        end else if (m_q.size() == NW) begin
            m_err   = 1'b1;
            m_drain = 1'b1;
            m_q.delete();
        end
    endfunction

    function automatic void m_trigger();
        if (m_ready) begin
            m_front = m_back;
            m_cnt   = m_cnt + 32'd1;
            m_ready = 1'b0;
        end else begin
            m_under = 1'b1;
        end
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_data"},     data_out,  m_front);
        chk({tag, "_cnt"},      frame_cnt, m_cnt);
        chk({tag, "_underrun"}, underrun,  m_under);
        chk({tag, "_load_err"}, load_err,  m_err);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offer one word and wait (bounded) for the handshake. The optional
    // trigger lands in the same cycle as the handshake.
    task automatic send_word(input logic [31:0] d, input logic last, input bit with_trig);
        int n;
        tdata  = d;
        tlast  = last;
        tvalid = 1'b1;
        n = 0;
        while (!tready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("tready_wait", tready, 1'b1);
        if (!tready) begin
            tvalid = 1'b0;
            tlast  = 1'b0;
            return;
        end
        if (with_trig) trig_in = 1'b1;
        @(posedge clk);
        #1;
        tvalid  = 1'b0;
        tlast   = 1'b0;
        trig_in = 1'b0;
        if (with_trig) m_trigger();
        m_accept(d, last);
        $display("word data=%h last=%0b trig=%0b", d, last, with_trig);
        if (with_trig) begin
            chk("coll_trig_out", trig_out, 1'b1);
            check_all("coll");
        end
    endtask

    task automatic trigger(input string tag);
        trig_in = 1'b1;
        @(posedge clk);
        #1;
        trig_in = 1'b0;
        m_trigger();
        $display("trigger %s data_out=%h frame_cnt=%0d", tag, data_out, frame_cnt);
        chk({tag, "_trig_out"}, trig_out, 1'b1);
        check_all(tag);
        @(posedge clk);
        #1;
        chk({tag, "_trig_width"}, trig_out, 1'b0);
    endtask

    task automatic send_frame(input int last_at, input int nwords, input bit gaps);
        for (int i = 0; i < nwords; i++) begin
            if (gaps) idle_cycles($urandom_range(0, 2));
            send_word($urandom, (i == last_at), 1'b0);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1; en = 1'b0; trig_in = 1'b0;
        tvalid = 1'b0; tlast = 1'b0; tdata = '0;
        m_reset();
        idle_cycles(2);
        chk("rst_tready", tready, 1'b0);
        chk("rst_trig_out", trig_out, 1'b0);
        check_all("rst");

        rst = 1'b0;
        idle_cycles(1);
        en = 1'b1;
        idle_cycles(1);
        chk("en_tready", tready, 1'b1);

        // Basic frame
        send_word(32'h1111_1111, 1'b0, 1'b0);
        send_word(32'h2222_2222, 1'b0, 1'b0);
        send_word(32'h3333_3333, 1'b1, 1'b0);
        chk("basic_tready_after_last", tready, 1'b0);
        idle_cycles(2);
        chk("basic_tready_hold", tready, 1'b0);
        chk("basic_no_trig", trig_out, 1'b0);
        trigger("basic");
        chk("basic_data_const", data_out, 96'h3333_3333_2222_2222_1111_1111);
        chk("basic_cnt_const", frame_cnt, 32'd1);

        // Underrun: one word, trigger, then finish the frame
        send_frame(-1, 1, 1'b0);
        trigger("under");
        chk("under_flag", underrun, 1'b1);
        send_word($urandom, 1'b0, 1'b0);
        send_word($urandom, 1'b1, 1'b0);
        trigger("under_swap");

        // Early TLAST on second word
        send_frame(1, 2, 1'b0);
        chk("early_err", load_err, 1'b1);
        send_frame(2, 3, 1'b0);
        trigger("early_next");

        // Missing TLAST, then two junk words drained
        send_frame(-1, 3, 1'b0);
        chk("miss_err", load_err, 1'b1);
        chk("drain_tready", tready, 1'b1);
        send_frame(1, 2, 1'b0);
        send_frame(2, 3, 1'b0);
        trigger("miss_next");

        // Trigger collides with final word handshake
        send_word($urandom, 1'b0, 1'b0);
        send_word($urandom, 1'b0, 1'b0);
        send_word($urandom, 1'b1, 1'b1);
        idle_cycles(1);
        trigger("coll_swap");

        // EN drop mid-frame
        send_frame(-1, 2, 1'b0);
        en = 1'b0;
        idle_cycles(1);
        m_front = '0; m_ready = 1'b0; m_drain = 1'b0; m_q.delete();
        chk("endrop_tready", tready, 1'b0);
        check_all("endrop");
        trig_in = 1'b1;
        idle_cycles(1);
        trig_in = 1'b0;
        chk("idle_trig_ignored", trig_out, 1'b0);
        en = 1'b1;
        idle_cycles(1);
        m_under = 1'b0; m_err = 1'b0;
        check_all("reen");
        chk("reen_tready", tready, 1'b1);
        send_frame(2, 3, 1'b0);
        trigger("reen_swap");

        // Random frames with gaps and occasional early triggers
        for (int k = 0; k < 6; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                send_frame(-1, 1, 1'b1);
                trigger("rand_under");
                send_word($urandom, 1'b0, 1'b0);
                send_word($urandom, 1'b1, 1'b0);
            end else begin
                send_frame(2, 3, 1'b1);
            end
            idle_cycles($urandom_range(0, 3));
            trigger("rand_swap");
        end

        // Asynchronous reset mid-transfer
        send_word($urandom, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        m_reset();
        chk("arst_tready", tready, 1'b0);
        chk("arst_trig_out", trig_out, 1'b0);
        check_all("arst");
        idle_cycles(2);
        rst = 1'b0;
        idle_cycles(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/azimuth_frame_loader.md
Name: azimuth_frame_loader

Overview:
- Sequencer that feeds the azimuth signal generator one SIZE-bit target frame per radar trigger.
- Receives frames as an AXI4-Stream of WORD-bit words (from a DMA/FIFO) and assembles each into a back buffer.
- On each trigger, swaps the back buffer into the front buffer driving the generator's DATA bus, and issues the generator's TRIG.
- Detects underrun (trigger before a frame is complete) and framing errors.

Parameters:
- SIZE, 3200, frame width in bits; matches the generator SIZE.
- WORD, 32, stream word width.
- NW (localparam), ceil(SIZE/WORD), words per frame.
  - Bits of the last word beyond SIZE are discarded.

Ports:
- SYS_CLK  in  1  system clock, 100 MHz.
- RST  in  1  asynchronous, active-high reset.
- EN  in  1  block enable; low forces idle.
- TRIG_IN  in  1  single-cycle radar trigger pulse, synchronous to SYS_CLK.
- S_AXIS_TDATA  in  WORD  frame word; word k carries frame bits [k*WORD +: WORD].
- S_AXIS_TVALID  in  1  stream valid.
- S_AXIS_TLAST  in  1  marks word NW-1 of a frame.
- S_AXIS_TREADY  out  1  stream ready.
- DATA_OUT  out  SIZE  front buffer; connects to the generator DATA.
- TRIG_OUT  out  1  one-cycle pulse; connects to the generator TRIG.
- FRAME_CNT  out  32  number of successful swaps.
- UNDERRUN  out  1  sticky flag.
- LOAD_ERR  out  1  sticky flag.

Behaviour:
- Reset (RST=1, asynchronous):
  - State IDLE, word_idx=0.
  - S_AXIS_TREADY=0, DATA_OUT=0, TRIG_OUT=0, FRAME_CNT=0, UNDERRUN=0, LOAD_ERR=0, back buffer=0.
- All outputs are registered.
- A word is accepted when TVALID & TREADY.
- States:
  - IDLE: TREADY=0.
    - EN=1 → FILL.
    - The cycle EN rises, UNDERRUN and LOAD_ERR clear.
  - FILL: TREADY=1.
    - Each accepted word is written to back[word_idx*WORD +: WORD]; word_idx increments.
    - Accepted word with word_idx=NW-1 and TLAST=1 → READY, word_idx=0.
    - TLAST=1 at word_idx<NW-1 → LOAD_ERR=1, partial frame discarded, word_idx=0, stay FILL.
    - word_idx=NW-1 with TLAST=0 → LOAD_ERR=1, go to DRAIN.
  - DRAIN: TREADY=1; words are discarded until one is accepted with TLAST=1 → FILL, word_idx=0.
  - READY: TREADY=0 (backpressure holds the next frame in the upstream FIFO).
    - On TRIG_IN: next cycle DATA_OUT=back, TRIG_OUT=1, FRAME_CNT+1, state → FILL.
- Trigger while in FILL or DRAIN (underrun):
  - Next cycle TRIG_OUT=1 with DATA_OUT unchanged (previous frame repeats).
  - UNDERRUN=1; FRAME_CNT unchanged; fill continues undisturbed.
- TRIG_IN in the same cycle as acceptance of the final word counts as underrun. The frame lands in READY and is swapped on the following trigger.
- Trigger in IDLE: ignored.
- TRIG_OUT latency: exactly 1 cycle after TRIG_IN, width exactly 1 cycle.
- FRAME_CNT wraps 2^32-1 → 0.
- EN deassert mid-operation, effective next cycle:
  - State IDLE, TREADY=0, TRIG_OUT=0, DATA_OUT=0, word_idx=0; partial frame discarded.
  - FRAME_CNT holds its value.
  - Upstream must flush its FIFO before re-enable.
- RST mid-transfer: immediate return to reset values; an in-flight handshake is not completed.

Test Plan (SIZE=96, WORD=32, NW=3):
- Basic: EN=1; stream 0x11111111, 0x22222222, 0x33333333 (TLAST on 3rd); TRIG_IN pulse → 1 cycle later DATA_OUT=0x333333332222222211111111, TRIG_OUT high 1 cycle, FRAME_CNT=1; TREADY=0 after 3rd word until the trigger.
- Underrun: after the first swap, send only 1 word, then TRIG_IN → TRIG_OUT pulses, DATA_OUT unchanged, UNDERRUN=1, FRAME_CNT=1; finish 2 words + TRIG_IN → new frame swapped, FRAME_CNT=2.
- Early TLAST: TLAST on 2nd word → LOAD_ERR=1; the next 3-word frame loads correctly and swaps on trigger.
- Missing TLAST: 3rd word TLAST=0, then 2 junk words with TLAST on the 2nd → DRAIN discards them; the following frame is correct; LOAD_ERR=1.
- Collision: TRIG_IN in the same cycle as the last word handshake → UNDERRUN=1, DATA_OUT old; next TRIG_IN swaps in the new frame.
- EN drop mid-frame after 2 words → DATA_OUT=0, TREADY=0; on re-enable, flags clear and a fresh 3-word frame loads; FRAME_CNT retained.
